task_dispatcher: RTL

- Sequencer between task memory and the compute cores.
- Walks task memory from address 0 and parses group headers.
- For each group, issues each code task line to the lowest-index free core, then holds a barrier until every core in the group reports done.
- Host side is a start/busy/done/error interface. Task memory is read through a synchronous read port with 1-cycle latency.

---
 rtl/task_dispatcher.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/task_dispatcher.sv
// task_dispatcher: walks task memory from address 0 and parses group headers.
// For each group it hands every code line to the lowest-index free core, then
// holds a barrier until every core in the group reports done.
// Optional build macro: DISPATCH_PERF_CNT_EN adds run/stall cycle counters.
//
// Line format: a header has word1 == all ones and carries the group size N in
// word0[ADDR_W:0]. N == 0 ends the program. Any other line is a code line. Code
// lines inside a group are issued verbatim and never checked for the header
// pattern.
module task_dispatcher #(
  parameter int CORE_COUNT     = 4,
  parameter int TASK_MEM_DEPTH = 16,
  parameter int INSN_COUNT     = 16,
  parameter int INSN_SIZE      = 16,
  parameter int ADDR_W         = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic                             tm_rd_en,
  output logic [ADDR_W-1:0]                tm_addr,
  input  logic [INSN_COUNT*INSN_SIZE-1:0]  tm_rd_data,
  output logic [CORE_COUNT-1:0]            core_start,
  output logic [INSN_COUNT*INSN_SIZE-1:0]  core_task,
  input  logic [CORE_COUNT-1:0]            core_done
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_run_cycles,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  // The pointer is one bit wider than the address so that running off the end
  // of memory is visible as ptr == TASK_MEM_DEPTH instead of wrapping to 0.
  localparam logic [ADDR_W:0] PTR_END = (ADDR_W+1)'(TASK_MEM_DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HDR,
    WAIT_HDR,
    FETCH_TASK,
    WAIT_TASK,
    ISSUE,
    BARRIER,
    DONE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_W:0]         ptr;
  logic [ADDR_W:0]         remaining;
  logic [CORE_COUNT-1:0]   busy_vec;
  logic [CORE_COUNT-1:0]   ready;
  logic [CORE_COUNT-1:0]   grant;
  logic                    is_header;
  logic [ADDR_W:0]         hdr_count;
  logic                    ptr_at_end;
  logic                    start_ok;
  logic                    issue_fire;

  // Decode of the line returned by task memory and of the free-core set.
  always_comb begin
    is_header  = (tm_rd_data[2*INSN_SIZE-1:INSN_SIZE] == {INSN_SIZE{1'b1}});
    hdr_count  = tm_rd_data[ADDR_W:0];
    ptr_at_end = (ptr == PTR_END);
    start_ok   = start && ((state == IDLE) || (state == DONE));
    ready      = ~busy_vec;
    grant      = ready & (~ready + CORE_COUNT'(1));
    issue_fire = (state == ISSUE) && (ready != '0);
  end

  // State register; reset returns to IDLE on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an address overrun inside a group still lets the
  // barrier drain, and the sticky error then routes the barrier to DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = FETCH_HDR;
      end
      FETCH_HDR: begin
        next_state = ptr_at_end ? DONE : WAIT_HDR;
      end
      WAIT_HDR: begin
        if (!is_header || (hdr_count == '0)) next_state = DONE;
        else                                 next_state = FETCH_TASK;
      end
      FETCH_TASK: begin
        next_state = ptr_at_end ? BARRIER : WAIT_TASK;
      end
      WAIT_TASK: begin
        next_state = ISSUE;
      end
      ISSUE: begin
        if (issue_fire) next_state = (remaining == ONE) ? BARRIER : FETCH_TASK;
      end
      BARRIER: begin
        if (busy_vec == '0) next_state = error ? DONE : FETCH_HDR;
      end
      DONE: begin
        if (start) next_state = FETCH_HDR;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath registers: pointer, group countdown, sticky error, core tracking.
  // An issue is ORed in after the done mask so it wins on the same core.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      error     <= 1'b0;
      busy_vec  <= '0;
      core_task <= '0;
      done      <= 1'b0;
    end else begin
      done     <= (next_state == DONE) && (state != DONE);
      busy_vec <= (busy_vec & ~core_done) | core_start;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ptr   <= '0;
            error <= 1'b0;
          end
        end
        FETCH_HDR: begin
          if (ptr_at_end) error <= 1'b1;
        end
        WAIT_HDR: begin
          if (!is_header) begin
            error <= 1'b1;
          end else if (hdr_count != '0) begin
            remaining <= hdr_count;
            ptr       <= ptr + ONE;
          end
        end
        FETCH_TASK: begin
          if (ptr_at_end) error <= 1'b1;
        end
        WAIT_TASK: begin
          core_task <= tm_rd_data;
        end
        ISSUE: begin
          if (issue_fire) begin
            ptr       <= ptr + ONE;
            remaining <= remaining - ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the current state; reads are suppressed past the end.
  always_comb begin
    busy       = (state != IDLE) && (state != DONE);
    tm_rd_en   = ((state == FETCH_HDR) || (state == FETCH_TASK)) && !ptr_at_end;
    tm_addr    = ptr[ADDR_W-1:0];
    core_start = issue_fire ? grant : '0;
  end

`ifdef DISPATCH_PERF_CNT_EN
  // Performance counters: cleared by an accepted start, frozen once busy drops.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      perf_run_cycles   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy) perf_run_cycles <= perf_run_cycles + 32'd1;
      if (((state == ISSUE) && (ready == '0)) || (state == BARRIER))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
